// File: rtl/Purple_Jade_pkg.sv
// Shared types and sizes for the reorder buffer and its writeback/commit interfaces.
package Purple_Jade_pkg;

   localparam int WORD_SIZE_P  = 16;
   localparam int NUM_PHYS_REG = 32;
   localparam int NUM_FLAGS    = 4;
   localparam int ROB_ENTRY    = 16;

   localparam int ROB_IW = $clog2(ROB_ENTRY);
   localparam int PREG_W = $clog2(NUM_PHYS_REG);

   // Occupancy value that means every entry is in use.
   localparam logic [ROB_IW:0] ROB_FULL_COUNT = (ROB_IW + 1)'(ROB_ENTRY);

   // Common data bus payload produced by a functional unit.
   typedef struct packed {
      logic                   valid;
      logic [PREG_W-1:0]      dest;
      logic [NUM_FLAGS-1:0]   flags;
      logic [WORD_SIZE_P-1:0] result;
   } cdb_t;

   // FU writeback: bus payload tagged with the ROB entry it completes.
   typedef struct packed {
      cdb_t              cdb;
      logic [ROB_IW-1:0] rob_dest;
   } rob_wb_t;

   // Architectural commit packet.
   typedef struct packed {
      cdb_t cdb;
      logic w_v;
   } reg_wb_t;

   localparam int ROB_WB_WIDTH = $bits(rob_wb_t);
   localparam int REG_WB_WIDTH = $bits(reg_wb_t);

   // One reorder-buffer slot.
   typedef struct packed {
      logic                   valid;
      logic                   done;
      logic                   w_v;
      logic [PREG_W-1:0]      dest;
      logic [NUM_FLAGS-1:0]   flags;
      logic [WORD_SIZE_P-1:0] result;
   } rob_entry_t;

endpackage

// File: rtl/rob_wb_commit_port_decode.sv
// Unpacks one FU writeback port and turns its ROB tag into a one-hot entry enable.
module rob_wb_port_decode
   import Purple_Jade_pkg::*;
(
   input  logic [ROB_WB_WIDTH-1:0] wb_i,
   output logic [ROB_ENTRY-1:0]    we_o,
   output logic [WORD_SIZE_P-1:0]  result_o,
   output logic [NUM_FLAGS-1:0]    flags_o
);

   rob_wb_t wb;
   logic    unused_dest;

   assign wb       = rob_wb_t'(wb_i);
   assign result_o = wb.cdb.result;
   assign flags_o  = wb.cdb.flags;

   // The destination register comes from the ROB entry, not from the bus.
   assign unused_dest = ^wb.cdb.dest;

   // One-hot enable for the tagged entry, only while the bus carries a valid result.
   always_comb begin
      // NOTE: combinational logic uses blocking '=' with a default assigned first, so no latch is inferred.
      we_o = '0;
      if (wb.cdb.valid) begin
         we_o[wb.rob_dest] = 1'b1;
      end
   end

endmodule

// File: rtl/rob_wb_commit.sv
// In-order reorder buffer: dispatch allocates at the tail, FU writebacks mark entries
// done, and done entries retire one per cycle from the head as a reg_wb_t packet.
module rob_wb_commit
   import Purple_Jade_pkg::*;
#(
   parameter int NUM_WB_PORTS = 2
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic                                 flush_i,
   input  logic                                 alloc_v_i,
   input  logic [PREG_W-1:0]                    alloc_dest_i,
   input  logic                                 alloc_w_v_i,
   output logic [ROB_IW-1:0]                    alloc_idx_o,
   output logic                                 full_o,
   output logic                                 empty_o,
   input  logic [NUM_WB_PORTS*ROB_WB_WIDTH-1:0] wb_i,
   output logic [REG_WB_WIDTH-1:0]              commit_o,
   output logic                                 commit_v_o,
   input  logic                                 commit_ready_i
);

   rob_entry_t        rob [ROB_ENTRY];
   logic [ROB_IW-1:0] head;
   logic [ROB_IW-1:0] tail;
   logic [ROB_IW:0]   count;

   logic                   alloc_fire;
   logic                   commit_fire;
   reg_wb_t                commit_pkt;

   logic [ROB_ENTRY-1:0]   port_we     [NUM_WB_PORTS];
   logic [WORD_SIZE_P-1:0] port_result [NUM_WB_PORTS];
   logic [NUM_FLAGS-1:0]   port_flags  [NUM_WB_PORTS];

   logic [ROB_ENTRY-1:0]   wb_hit;
   logic [WORD_SIZE_P-1:0] wb_result [ROB_ENTRY];
   logic [NUM_FLAGS-1:0]   wb_flags  [ROB_ENTRY];
   logic                   wb_collision;

   genvar gp;
   for (gp = 0; gp < NUM_WB_PORTS; gp++) begin : g_dec
      rob_wb_port_decode u_dec (
         .wb_i     (wb_i[gp*ROB_WB_WIDTH +: ROB_WB_WIDTH]),
         .we_o     (port_we[gp]),
         .result_o (port_result[gp]),
         .flags_o  (port_flags[gp])
      );
   end

   // Merge ports per entry; scanning high to low lets the lowest-numbered port win.
   always_comb begin
      wb_hit       = '0;
      wb_collision = 1'b0;
      for (int i = 0; i < ROB_ENTRY; i++) begin
         wb_result[i] = '0;
         wb_flags[i]  = '0;
         for (int p = NUM_WB_PORTS - 1; p >= 0; p--) begin
            if (port_we[p][i]) begin
               if (wb_hit[i] && rob[i].valid) begin
                  wb_collision = 1'b1;
               end
               wb_hit[i]    = 1'b1;
               wb_result[i] = port_result[p];
               wb_flags[i]  = port_flags[p];
            end
         end
      end
   end

   assign full_o      = (count == ROB_FULL_COUNT);
   assign empty_o     = (count == '0);
   assign alloc_idx_o = tail;
   assign commit_v_o  = rob[head].valid & rob[head].done;
   assign alloc_fire  = alloc_v_i && !full_o;
   assign commit_fire = commit_v_o && commit_ready_i;

   // Build the commit packet straight from the head slot so it holds while stalled.
   always_comb begin
      commit_pkt            = '0;
      commit_pkt.cdb.valid  = commit_v_o;
      commit_pkt.cdb.dest   = rob[head].dest;
      commit_pkt.cdb.flags  = rob[head].flags;
      commit_pkt.cdb.result = rob[head].result;
      commit_pkt.w_v        = commit_v_o & rob[head].w_v;
   end

   assign commit_o = commit_pkt;

   // Pointer, occupancy and slot updates; reset and flush both return to the empty state.
   always_ff @(posedge clk_i) begin
      // NOTE: all state is updated with non-blocking '<=' so every read sees the pre-edge value.
      if (!reset_i || flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         // NOTE: the whole slot array is cleared, not just valid/done, so commit_o reads zero afterwards.
         for (int i = 0; i < ROB_ENTRY; i++) begin
            rob[i] <= '0;
         end
      end else begin
         for (int i = 0; i < ROB_ENTRY; i++) begin
            if (wb_hit[i] && rob[i].valid) begin
               rob[i].result <= wb_result[i];
               rob[i].flags  <= wb_flags[i];
               rob[i].done   <= 1'b1;
            end
         end
         if (alloc_fire) begin
            rob[tail].valid <= 1'b1;
            rob[tail].done  <= 1'b0;
            rob[tail].w_v   <= alloc_w_v_i;
            rob[tail].dest  <= alloc_dest_i;
            tail            <= tail + 1'b1;
         end
         if (commit_fire) begin
            rob[head].valid <= 1'b0;
            rob[head].done  <= 1'b0;
            head            <= head + 1'b1;
         end
         case ({alloc_fire, commit_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Two ports completing the same live entry in one cycle is a protocol error.
   assert property (@(posedge clk_i) disable iff (!reset_i) !wb_collision);

endmodule

// File: tb/tb_rob_wb_commit.sv
// Self-checking bench for rob_wb_commit: directed scenarios followed by random traffic,
// compared every cycle against a queue-based model of the reorder buffer.
module tb_rob_wb_commit;
   import Purple_Jade_pkg::*;

   localparam int NP = 2;

   logic                       clk = 1'b0;
   logic                       reset_i;
   logic                       flush_i;
   logic                       alloc_v_i;
   logic [PREG_W-1:0]          alloc_dest_i;
   logic                       alloc_w_v_i;
   logic [ROB_IW-1:0]          alloc_idx_o;
   logic                       full_o;
   logic                       empty_o;
   logic [NP*ROB_WB_WIDTH-1:0] wb_i;
   logic [REG_WB_WIDTH-1:0]    commit_o;
   logic                       commit_v_o;
   logic                       commit_ready_i;

   rob_wb_commit #(.NUM_WB_PORTS(NP)) dut (
      .clk_i          (clk),
      .reset_i        (reset_i),
      .flush_i        (flush_i),
      .alloc_v_i      (alloc_v_i),
      .alloc_dest_i   (alloc_dest_i),
      .alloc_w_v_i    (alloc_w_v_i),
      .alloc_idx_o    (alloc_idx_o),
      .full_o         (full_o),
      .empty_o        (empty_o),
      .wb_i           (wb_i),
      .commit_o       (commit_o),
      .commit_v_o     (commit_v_o),
      .commit_ready_i (commit_ready_i)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Writeback stimulus as the model sees it.
   logic                   wb_v   [NP];
   int                     wb_idx [NP];
   logic [WORD_SIZE_P-1:0] wb_res [NP];
   logic [NUM_FLAGS-1:0]   wb_flg [NP];

   // Model: live entries in program order, oldest first, plus the next index to hand out.
   typedef struct {
      int                     idx;
      logic [PREG_W-1:0]      dest;
      logic                   w_v;
      logic                   done;
      logic [WORD_SIZE_P-1:0] result;
      logic [NUM_FLAGS-1:0]   flags;
   } m_ent_t;

   m_ent_t mq[$];
   int     m_tail;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_wb(input int p, input logic v, input int idx,
                         input logic [WORD_SIZE_P-1:0] res, input logic [NUM_FLAGS-1:0] flg);
      rob_wb_t t;
      wb_v[p]   = v;
      wb_idx[p] = idx;
      wb_res[p] = res;
      wb_flg[p] = flg;
      t              = '0;
      t.cdb.valid    = v;
      t.cdb.dest     = PREG_W'($urandom);
      t.cdb.flags    = flg;
      t.cdb.result   = res;
      t.rob_dest     = idx[ROB_IW-1:0];
      wb_i[p*ROB_WB_WIDTH +: ROB_WB_WIDTH] = t;
   endtask

   task automatic idle();
      flush_i        = 1'b0;
      alloc_v_i      = 1'b0;
      alloc_dest_i   = '0;
      alloc_w_v_i    = 1'b0;
      commit_ready_i = 1'b0;
      for (int p = 0; p < NP; p++) set_wb(p, 1'b0, 0, '0, '0);
   endtask

   function automatic bit is_live(input int i);
      foreach (mq[k]) if (mq[k].idx == i) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_outputs();
      reg_wb_t e;
      logic    ecv;
      ecv = (mq.size() > 0) && mq[0].done;
      check("alloc_idx", 64'(alloc_idx_o), 64'(m_tail));
      check("full", 64'(full_o), 64'(mq.size() == ROB_ENTRY));
      check("empty", 64'(empty_o), 64'(mq.size() == 0));
      check("commit_v", 64'(commit_v_o), 64'(ecv));
      if (ecv) begin
         e.cdb.valid  = 1'b1;
         e.cdb.dest   = mq[0].dest;
         e.cdb.flags  = mq[0].flags;
         e.cdb.result = mq[0].result;
         e.w_v        = mq[0].w_v;
         check("commit_o", 64'(commit_o), 64'(e));
      end
   endtask

   task automatic model_step();
      logic cfire;
      logic afire;
      if (!reset_i || flush_i) begin
         mq.delete();
         m_tail = 0;
         return;
      end
      cfire = (mq.size() > 0) && mq[0].done && commit_ready_i;
      afire = alloc_v_i && (mq.size() < ROB_ENTRY);
      foreach (mq[k]) begin
         for (int p = 0; p < NP; p++) begin
            if (wb_v[p] && wb_idx[p] == mq[k].idx) begin
               mq[k].done   = 1'b1;
               mq[k].result = wb_res[p];
               mq[k].flags  = wb_flg[p];
               break;
            end
         end
      end
      if (cfire) void'(mq.pop_front());
      if (afire) begin
         mq.push_back('{idx: m_tail, dest: alloc_dest_i, w_v: alloc_w_v_i,
                        done: 1'b0, result: '0, flags: '0});
         m_tail = (m_tail + 1) % ROB_ENTRY;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle();
      check_outputs();
      model_step();
      tick();
   endtask

   task automatic do_reset();
      idle();
      reset_i = 1'b0;
      cycle();
      reset_i = 1'b1;
   endtask

   reg_wb_t obs;
   reg_wb_t snap;

   initial begin
      idle();
      reset_i = 1'b0;
      mq.delete();
      m_tail = 0;
      tick();
      tick();
      reset_i = 1'b1;

      // 1: state after reset
      check("rst_empty", 64'(empty_o), 64'd1);
      check("rst_full", 64'(full_o), 64'd0);
      check("rst_commit_v", 64'(commit_v_o), 64'd0);
      check("rst_alloc_idx", 64'(alloc_idx_o), 64'd0);
      check("rst_commit_o", 64'(commit_o), 64'd0);

      // 2: out-of-order writeback, in-order commit
      commit_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         alloc_v_i    = 1'b1;
         alloc_dest_i = PREG_W'(i + 3);
         alloc_w_v_i  = (i != 1);
         cycle();
      end
      alloc_v_i = 1'b0;
      set_wb(0, 1'b1, 1, 16'h0005, 4'h2);
      set_wb(1, 1'b1, 0, 16'hFFFF, 4'h9);
      cycle();
      set_wb(0, 1'b0, 0, '0, '0);
      set_wb(1, 1'b0, 0, '0, '0);
      obs = commit_o;
      check("t2_first_res", 64'(obs.cdb.result), 64'hFFFF);
      cycle();
      obs = commit_o;
      check("t2_second_res", 64'(obs.cdb.result), 64'h0005);
      check("t2_second_w_v", 64'(obs.w_v), 64'd0);
      cycle();
      check("t2_idx2_held", 64'(commit_v_o), 64'd0);
      cycle();

      // 3: fill, refuse when full, refuse alloc alongside a commit, then wrap
      do_reset();
      for (int i = 0; i < ROB_ENTRY; i++) begin
         alloc_v_i    = 1'b1;
         alloc_dest_i = PREG_W'($urandom);
         alloc_w_v_i  = 1'($urandom);
         cycle();
      end
      check("t3_full", 64'(full_o), 64'd1);
      cycle();
      check("t3_tail_stays", 64'(alloc_idx_o), 64'd0);
      alloc_v_i = 1'b0;
      set_wb(0, 1'b1, 0, 16'h1234, 4'h1);
      cycle();
      set_wb(0, 1'b0, 0, '0, '0);
      alloc_v_i      = 1'b1;
      commit_ready_i = 1'b1;
      cycle();
      check("t3_refused_idx", 64'(alloc_idx_o), 64'd0);
      check("t3_refused_full", 64'(full_o), 64'd0);
      commit_ready_i = 1'b0;
      cycle();
      check("t3_wrap_idx", 64'(alloc_idx_o), 64'd1);
      check("t3_wrap_full", 64'(full_o), 64'd1);
      alloc_v_i = 1'b0;

      // 4: commit held by backpressure stays stable
      set_wb(1, 1'b1, 1, 16'hA5A5, 4'h3);
      cycle();
      set_wb(1, 1'b0, 0, '0, '0);
      snap = commit_o;
      for (int i = 0; i < 3; i++) begin
         check("t4_stable", 64'(commit_o), 64'(snap));
         check("t4_held_v", 64'(commit_v_o), 64'd1);
         cycle();
      end
      commit_ready_i = 1'b1;
      cycle();
      commit_ready_i = 1'b0;
      check("t4_advanced", 64'(commit_v_o), 64'd0);
      check("t4_not_full", 64'(full_o), 64'd0);

      // 5: flush beats alloc, wb and commit; later wb to a flushed index is ignored
      do_reset();
      for (int i = 0; i < 5; i++) begin
         alloc_v_i    = 1'b1;
         alloc_dest_i = PREG_W'($urandom);
         alloc_w_v_i  = 1'b1;
         cycle();
      end
      alloc_v_i = 1'b0;
      set_wb(0, 1'b1, 0, 16'h0101, 4'h4);
      set_wb(1, 1'b1, 1, 16'h0202, 4'h5);
      cycle();
      flush_i        = 1'b1;
      alloc_v_i      = 1'b1;
      commit_ready_i = 1'b1;
      set_wb(0, 1'b1, 2, 16'h0303, 4'h6);
      set_wb(1, 1'b0, 0, '0, '0);
      cycle();
      idle();
      check("t5_empty", 64'(empty_o), 64'd1);
      check("t5_alloc_idx", 64'(alloc_idx_o), 64'd0);
      check("t5_commit_o", 64'(commit_o), 64'd0);
      set_wb(0, 1'b1, 3, 16'h0404, 4'h7);
      cycle();
      set_wb(0, 1'b0, 0, '0, '0);
      check("t5_wb_ignored", 64'(commit_v_o), 64'd0);
      alloc_v_i = 1'b1;
      set_wb(0, 1'b1, 0, 16'h0505, 4'h8);
      cycle();
      idle();
      check("t5_alloc_wb_drop", 64'(commit_v_o), 64'd0);
      check("t5_one_live", 64'(empty_o), 64'd0);
      cycle();

      // 6: reset wins over a ready commit
      do_reset();
      for (int i = 0; i < 4; i++) begin
         alloc_v_i    = 1'b1;
         alloc_dest_i = PREG_W'($urandom);
         alloc_w_v_i  = 1'b1;
         cycle();
      end
      alloc_v_i = 1'b0;
      set_wb(0, 1'b1, 0, 16'h1111, 4'h1);
      set_wb(1, 1'b1, 1, 16'h2222, 4'h2);
      cycle();
      set_wb(0, 1'b1, 2, 16'h3333, 4'h3);
      set_wb(1, 1'b1, 3, 16'h4444, 4'h4);
      cycle();
      idle();
      commit_ready_i = 1'b1;
      reset_i        = 1'b0;
      cycle();
      reset_i        = 1'b1;
      commit_ready_i = 1'b0;
      check("t6_empty", 64'(empty_o), 64'd1);
      check("t6_commit_v", 64'(commit_v_o), 64'd0);
      check("t6_commit_o", 64'(commit_o), 64'd0);
      check("t6_alloc_idx", 64'(alloc_idx_o), 64'd0);

      // Random traffic against the model
      for (int c = 0; c < 400; c++) begin
         int cand[$];
         int pick0;
         int r;
         int tgt;
         alloc_v_i      = ($urandom_range(0, 9) < 6);
         alloc_dest_i   = PREG_W'($urandom);
         alloc_w_v_i    = 1'($urandom);
         commit_ready_i = ($urandom_range(0, 9) < 7);
         flush_i        = ($urandom_range(0, 99) < 2);
         pick0 = -1;
         for (int p = 0; p < NP; p++) begin
            cand.delete();
            r = int'($urandom_range(0, 99));
            if (r < 55) begin
               foreach (mq[k]) if (!mq[k].done && mq[k].idx != pick0) cand.push_back(mq[k].idx);
            end else if (r < 65) begin
               for (int i = 0; i < ROB_ENTRY; i++) if (!is_live(i) && i != pick0) cand.push_back(i);
            end
            if (cand.size() > 0) begin
               tgt = cand[$urandom_range(0, cand.size() - 1)];
               set_wb(p, 1'b1, tgt, WORD_SIZE_P'($urandom), NUM_FLAGS'($urandom));
               if (p == 0) pick0 = tgt;
            end else begin
               set_wb(p, 1'b0, 0, '0, '0);
            end
         end
         cycle();
      end
      idle();
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
